mdio_phy_responder: RTL and testbench
=====================================

// Module: mdio_phy_responder
// PURPOSE
//  Clause-22 MDIO target (PHY-side management responder) for the Ethernet subsystem.
//  - Answers the MDC/MDIO frames that the TSE MAC management master issues.
//  - Holds a 32x16 PHY register file.
//  - Bench use: a loopback PHY model. Also used in-fabric where the MAC faces an emulated PHY.
//  - MDC and MDIO are oversampled in the system clock domain. The block drives MDIO only during read turnaround/data.
// PARAMETERS
//  PHY_ADDR      5'd1      PHYAD this target answers to; all other PHYAD values are ignored
//  PREAMBLE_LEN  32        consecutive sampled 1s required before ST is accepted
//  PHY_ID1       16'h0141  reg 2 value (read-only)
//  PHY_ID2       16'h0CC2  reg 3 value (read-only)
//  BMCR_DEFAULT  16'h1140  reg 0 reset value
//  BMSR_BASE     16'h7949  reg 1 value; bit 2 replaced by link_up
// PORTS
//  clk           in   1   system clock; requires MDC high and low phases of >=4 clk each
//  reset         in   1   synchronous, active-high
//  mdc           in   1   management clock from the MAC (asynchronous to clk)
//  mdio_in       in   1   MDIO pad input
//  mdio_out      out  1   MDIO drive value
//  mdio_oen      out  1   active-low output enable (0 = drive pad); matches MAC-side convention
//  link_up       in   1   reflected in reg 1 bit 2
//  reg_wr_pulse  out  1   one-clk pulse when a write commits
//  reg_wr_addr   out  5   register address of the committed write
//  reg_wr_data   out  16  data of the committed write
//  busy          out  1   high from accepted ST until frame end or abort
// BEHAVIOUR
//  Reset values:
//   - mdio_oen=1, mdio_out=1, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, busy=0, state=IDLE.
//   - reg0=BMCR_DEFAULT; RW regs 4..31 = 0.
//  Sampling:
//   - mdc and mdio_in each pass a 2-FF synchroniser.
//   - A rising edge = synced mdc 0->1; synced mdio_in is sampled in that clk.
//   - Drive changes occur 1 clk after the detected edge, so drive follows the MDC rising edge.
//  States: IDLE -> ST -> OP -> PHYAD -> REGAD -> TA -> {RD_DATA | WR_DATA} -> IDLE.
//   IDLE:
//    - Count consecutive sampled 1s, saturating at PREAMBLE_LEN; any 0 clears the count.
//    - A 0 sampled with count==PREAMBLE_LEN -> ST, busy=1.
//   ST: next bit must be 1, else IDLE.
//   OP: 2 bits. 10=read, 01=write; 00/11 -> IDLE.
//   PHYAD:
//    - 5 bits, MSB first.
//    - Mismatch with PHY_ADDR -> IDLE; mdio_oen never asserts.
//   REGAD: 5 bits, MSB first. Let edge N = the edge sampling REGAD bit 0.
//   Read frame:
//    - After N: stay hi-Z.
//    - After N+1: mdio_oen=0, mdio_out=0 (TA second bit).
//    - After N+2..N+17: drive D15..D0.
//    - After N+18: mdio_oen=1, busy=0, -> IDLE.
//    - Read data is captured at edge N (snapshot); later register writes do not alter it.
//   Write frame:
//    - TA bits sampled at N+1, N+2 must be 1,0; else abort -> IDLE with no write.
//    - D15..D0 sampled at N+3..N+18.
//    - On the clk after N+18: commit; reg_wr_pulse=1 for 1 clk, addr/data registered; busy=0.
//  Register map:
//   - reg1 = BMSR_BASE with bit2=link_up, sampled at edge N.
//   - reg2/3 = ID params. Writes to regs 1..3 are discarded, but reg_wr_pulse still fires.
//   - reg0 bit15 (soft reset) on write:
//     - all RW regs return to reset values in the same commit cycle;
//     - reg0 bit15 always reads 0 (self-clearing).
//  Boundary cases:
//   - reset asserted mid-frame: next clk mdio_oen=1, busy=0, state=IDLE, registers at defaults.
//   - A partial frame (MDC stops) holds state indefinitely. No timeout; the next preamble does not resync mid-frame.
//   - Back-to-back frames with no preamble are not accepted (PREAMBLE_LEN>0 is required).
//   - Ones in data bits count toward the next preamble only after return to IDLE.
//  Bit counter: 5-bit, reloaded per field; no wrap beyond 16 data bits.
// STRUCTURE
//  - Shared package mdio_pkg:
//    - opcode constants OP_READ=2'b10, OP_WRITE=2'b01
//    - state enum
//    - register addresses BMCR=0, BMSR=1, PHYID1=2, PHYID2=3
//  - Sub-module mdio_edge_sync: 2-FF sync of mdc and mdio_in, emits mdc_rise pulse and mdio_s.
//  - Top: FSM + bit counter + shift registers + register file.
// TESTING
//  - Read PHYID2:
//    - 32x1 preamble, ST=01, OP=10, PHYAD=1, REGAD=3.
//    - Expect hi-Z TA bit 1, 0 on TA bit 2, then 16'h0CC2 MSB first; mdio_oen=1 after D0.
//  - Write then read back:
//    - write 16'hA5C3 to reg 4: expect reg_wr_pulse once, addr=4, data=A5C3;
//    - read reg 4: expect A5C3.
//  - Foreign PHYAD: read with PHYAD=2 -> mdio_oen stays 1 for the whole frame; busy drops after PHYAD.
//  - Short preamble: 31 ones then a valid read of reg 2 -> no response.
//    - Repeat with 32 ones -> 16'h0141.
//  - Soft reset:
//    - write reg4=16'h1234, then write reg0=16'h8000;
//    - read reg0 -> 16'h1140 (bit15 clear); read reg4 -> 16'h0000.
//  - Reset mid-read:
//    - assert reset during D8 of a read -> mdio_oen=1 next clk, busy=0;
//    - following full read of reg 1 with link_up=1 -> 16'h794D.

Source files
------------

// File: rtl/mdio_pkg.sv
// ---------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the Clause-22 MDIO PHY responder:
//   - management frame opcodes
//   - FSM state codes and the state type
//   - addresses of the fixed IEEE registers
// No ports; imported by mdio_edge_sync and mdio_phy_responder.
// ---------------------------------------------------------------------------
package mdio_pkg;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;

   // Frame-walk states, one per MDIO frame field.
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_ST      = 3'd1;
   localparam state_t S_OP      = 3'd2;
   localparam state_t S_PHYAD   = 3'd3;
   localparam state_t S_REGAD   = 3'd4;
   localparam state_t S_TA      = 3'd5;
   localparam state_t S_RD_DATA = 3'd6;
   localparam state_t S_WR_DATA = 3'd7;

   localparam logic [4:0] REG_BMCR   = 5'd0;
   localparam logic [4:0] REG_BMSR   = 5'd1;
   localparam logic [4:0] REG_PHYID1 = 5'd2;
   localparam logic [4:0] REG_PHYID2 = 5'd3;

endpackage

// File: rtl/mdio_edge_sync.sv
// ---------------------------------------------------------------------------
// mdio_edge_sync
// Brings MDC and MDIO into the system clock domain and flags MDC rising edges.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   mdc       in   management clock from the MAC (asynchronous)
//   mdio_in   in   MDIO pad input (asynchronous)
//   mdc_rise  out  one-clk pulse on a synchronised MDC 0->1 transition
//   mdio_s    out  synchronised MDIO, aligned with mdc_rise
// ---------------------------------------------------------------------------
module mdio_edge_sync
   import mdio_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic mdc,
   input  logic mdio_in,
   output logic mdc_rise,
   output logic mdio_s
);

   // mdc_q[1:0] is the 2-FF synchroniser, mdc_q[2] the previous synced value.
   logic [2:0] mdc_q, mdc_d;
   logic [1:0] mdio_q, mdio_d;

   always_comb begin
      mdc_d  = {mdc_q[1:0], mdc};
      mdio_d = {mdio_q[0], mdio_in};
   end

   // NOTE: non-blocking assignments make every flop load its pre-edge input;
   // blocking ones would collapse the synchroniser chain into a single stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdc_q  <= '0;
         mdio_q <= '1;
      end else begin
         mdc_q  <= mdc_d;
         mdio_q <= mdio_d;
      end
   end

   // Both signals have the same two-stage latency, so MDIO is sampled
   // exactly in the clk that sees the MDC edge.
   assign mdc_rise = mdc_q[1] & ~mdc_q[2];
   assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// ---------------------------------------------------------------------------
// mdio_phy_responder
// Clause-22 MDIO target with a 32x16 PHY register file. Decodes frames from
// the MAC management master on oversampled MDC/MDIO and drives MDIO only
// during the read turnaround and data bits.
// Ports:
//   clk           in   system clock (MDC phases must each last >= 4 clk)
//   reset         in   synchronous, active-high
//   mdc, mdio_in  in   management bus from the MAC
//   mdio_out      out  MDIO drive value
//   mdio_oen      out  active-low output enable (0 = drive pad)
//   link_up       in   reflected in reg 1 bit 2
//   reg_wr_pulse  out  one-clk pulse when a write commits
//   reg_wr_addr   out  register address of the committed write
//   reg_wr_data   out  data of the committed write
//   busy          out  high from accepted ST until frame end or abort
// ---------------------------------------------------------------------------
module mdio_phy_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter int          PREAMBLE_LEN = 32,
   parameter logic [15:0] PHY_ID1      = 16'h0141,
   parameter logic [15:0] PHY_ID2      = 16'h0CC2,
   parameter logic [15:0] BMCR_DEFAULT = 16'h1140,
   parameter logic [15:0] BMSR_BASE    = 16'h7949
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oen,
   input  logic        link_up,
   output logic        reg_wr_pulse,
   output logic [4:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        busy
);

   localparam int             PCW     = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PCW-1:0] PRE_MAX = PCW'(PREAMBLE_LEN);
   // BMCR bit 15 is self-clearing, so it is never stored.
   localparam logic [15:0]    BMCR_RST = BMCR_DEFAULT & 16'h7FFF;

   logic mdc_rise, mdio_s;

   mdio_edge_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .mdc      (mdc),
      .mdio_in  (mdio_in),
      .mdc_rise (mdc_rise),
      .mdio_s   (mdio_s)
   );

   state_t         state_q, state_d;
   logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
   logic [4:0]     bit_cnt_q, bit_cnt_d;  // bits left in the field, minus one
   logic [15:0]    sh_q, sh_d;            // incoming serial bits
   logic [15:0]    rd_q, rd_d;            // read snapshot, shifted out MSB first
   logic           is_read_q, is_read_d;
   logic [4:0]     regad_q, regad_d;
   logic           oen_q, oen_d, out_q, out_d, busy_q, busy_d;
   logic           wr_pulse_q, wr_pulse_d;
   logic [4:0]     wr_addr_q, wr_addr_d;
   logic [15:0]    wr_data_q, wr_data_d;
   logic [15:0]    bmcr_q, bmcr_d;
   logic [15:0]    rf_q [4:31];
   logic [15:0]    rf_d [4:31];

   logic        field_done;
   logic [4:0]  field5;
   logic [15:0] shift_in;

   assign field_done = (bit_cnt_q == 5'd0);
   assign shift_in   = {sh_q[14:0], mdio_s};
   assign field5     = shift_in[4:0];

   // NOTE: every _d gets its hold value first, so no path through this block
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      rd_d       = rd_q;
      is_read_d  = is_read_q;
      regad_d    = regad_q;
      oen_d      = oen_q;
      out_d      = out_q;
      busy_d     = busy_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      bmcr_d     = bmcr_q;
      rf_d       = rf_q;

      if (mdc_rise) begin
         if (state_q != S_IDLE) begin
            sh_d = shift_in;
            if (!field_done) bit_cnt_d = bit_cnt_q - 5'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (mdio_s) begin
                  if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
               end else begin
                  // The ST '0' is only accepted after a full preamble.
                  if (pre_cnt_q == PRE_MAX) begin
                     state_d   = S_ST;
                     busy_d    = 1'b1;
                     bit_cnt_d = 5'd0;
                  end
                  pre_cnt_d = '0;
               end
            end
            S_ST: begin
               if (mdio_s) begin
                  state_d   = S_OP;
                  bit_cnt_d = 5'd1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end
            S_OP: begin
               if (field_done) begin
                  if (field5[1:0] == OP_READ || field5[1:0] == OP_WRITE) begin
                     is_read_d = (field5[1:0] == OP_READ);
                     state_d   = S_PHYAD;
                     bit_cnt_d = 5'd4;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            S_PHYAD: begin
               if (field_done) begin
                  if (field5 == PHY_ADDR) begin
                     state_d   = S_REGAD;
                     bit_cnt_d = 5'd4;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            S_REGAD: begin
               if (field_done) begin
                  regad_d   = field5;
                  state_d   = S_TA;
                  bit_cnt_d = 5'd1;
                  // Snapshot here so later writes cannot change in-flight data.
                  case (field5)
                     REG_BMCR:   rd_d = bmcr_q;
                     REG_BMSR:   rd_d = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
                     REG_PHYID1: rd_d = PHY_ID1;
                     REG_PHYID2: rd_d = PHY_ID2;
                     default:    rd_d = rf_q[field5];
                  endcase
               end
            end
            S_TA: begin
               if (is_read_q) begin
                  if (!field_done) begin
                     oen_d = 1'b0;
                     out_d = 1'b0;
                  end else begin
                     out_d     = rd_q[15];
                     rd_d      = {rd_q[14:0], 1'b0};
                     state_d   = S_RD_DATA;
                     bit_cnt_d = 5'd15;
                  end
               end else if (mdio_s == field_done) begin
                  // Write turnaround must read 1 then 0.
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else if (field_done) begin
                  state_d   = S_WR_DATA;
                  bit_cnt_d = 5'd15;
               end
            end
            S_RD_DATA: begin
               if (!field_done) begin
                  out_d = rd_q[15];
                  rd_d  = {rd_q[14:0], 1'b0};
               end else begin
                  oen_d   = 1'b1;
                  out_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: begin  // S_WR_DATA
               if (field_done) begin
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = regad_q;
                  wr_data_d  = shift_in;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
                  // Writes to BMSR and the ID registers are dropped.
                  if (regad_q == REG_BMCR) begin
                     if (shift_in[15]) begin
                        bmcr_d = BMCR_RST;
                        for (int i = 4; i < 32; i++) rf_d[i] = '0;
                     end else begin
                        bmcr_d = shift_in;
                     end
                  end else if (regad_q >= 5'd4) begin
                     rf_d[regad_q] = shift_in;
                  end
               end
            end
         endcase
      end
   end

   // NOTE: the register file is reset explicitly because hard reset must
   // restore PHY defaults; a plain storage RAM would normally skip this.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pre_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         rd_q       <= '0;
         is_read_q  <= 1'b0;
         regad_q    <= '0;
         oen_q      <= 1'b1;
         out_q      <= 1'b1;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         bmcr_q     <= BMCR_RST;
         for (int i = 4; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         rd_q       <= rd_d;
         is_read_q  <= is_read_d;
         regad_q    <= regad_d;
         oen_q      <= oen_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         bmcr_q     <= bmcr_d;
         rf_q       <= rf_d;
      end
   end

   assign mdio_oen     = oen_q;
   assign mdio_out     = out_q;
   assign busy         = busy_q;
   assign reg_wr_pulse = wr_pulse_q;
   assign reg_wr_addr  = wr_addr_q;
   assign reg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// ---------------------------------------------------------------------------
// tb_mdio_phy_responder
// Drives MDC/MDIO frames into mdio_phy_responder and checks read responses
// and write commits against expected values held in scoreboard queues.
// ---------------------------------------------------------------------------
module tb_mdio_phy_responder;

   localparam int HALF = 8;  // clk cycles per MDC phase

   logic        clk = 1'b0;
   logic        reset, mdc, mdio_in, link_up;
   logic        mdio_out, mdio_oen, reg_wr_pulse, busy;
   logic [4:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;

   int errors = 0;
   int checks = 0;

   logic [15:0] rd_exp_q [$];
   logic [20:0] wr_seen_q [$];
   logic        obs_oen  [0:127];
   logic        obs_out  [0:127];
   logic        obs_busy [0:127];

   always #5 clk = ~clk;

   mdio_phy_responder dut (
      .clk          (clk),
      .reset        (reset),
      .mdc          (mdc),
      .mdio_in      (mdio_in),
      .mdio_out     (mdio_out),
      .mdio_oen     (mdio_oen),
      .link_up      (link_up),
      .reg_wr_pulse (reg_wr_pulse),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .busy         (busy)
   );

   // Every clk that reg_wr_pulse is high records one commit.
   always @(negedge clk) begin
      if (reg_wr_pulse === 1'b1) wr_seen_q.push_back({reg_wr_addr, reg_wr_data});
   end

   // One MDC period. Observations are taken just before the rising edge, so
   // obs_*[idx] shows what the DUT drives after edge idx-1.
   task automatic mdc_bit(input int idx, input logic b);
      mdio_in = b;
      repeat (HALF) @(negedge clk);
      obs_oen[idx]  = mdio_oen;
      obs_out[idx]  = mdio_out;
      obs_busy[idx] = busy;
      mdc = 1'b1;
      repeat (HALF) @(negedge clk);
      mdc = 1'b0;
   endtask

   // Frame: pre ones, ST, OP, PHYAD, REGAD, TA, 16 data bits, trailing 0.
   // Edge N (REGAD bit 0) is index pre+13. nbits < 0 sends the whole frame.
   task automatic run_frame(input bit wr, input logic [4:0] phyad, input logic [4:0] regad,
                            input logic [15:0] wdata, input logic [1:0] ta,
                            input int pre, input int nbits);
      logic [32:0] tail;
      int total;
      tail  = {2'b01, (wr ? 2'b01 : 2'b10), phyad, regad, ta, (wr ? wdata : 16'hFFFF), 1'b0};
      total = (nbits < 0) ? pre + 33 : nbits;
      for (int i = 0; i < total; i++) begin
         if (i < pre) mdc_bit(i, 1'b1);
         else         mdc_bit(i, tail[32 - (i - pre)]);
      end
      mdio_in = 1'b1;
   endtask

   task automatic check_read(input string name, input int pre);
      int          n;
      logic [15:0] got, exp;
      bit          drv_ok;
      n = pre + 13;
      checks++;
      if (obs_oen[n+1] !== 1'b1) begin
         errors++;
         $display("FAIL %s ta1_hiz: oen=%b want 1", name, obs_oen[n+1]);
      end
      checks++;
      if (obs_oen[n+2] !== 1'b0 || obs_out[n+2] !== 1'b0) begin
         errors++;
         $display("FAIL %s ta2_zero: oen=%b out=%b want 0 0", name, obs_oen[n+2], obs_out[n+2]);
      end
      drv_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         got[15-i] = obs_out[n+3+i];
         if (obs_oen[n+3+i] !== 1'b0) drv_ok = 1'b0;
      end
      checks++;
      if (!drv_ok) begin
         errors++;
         $display("FAIL %s data_oen: oen not low for all 16 data bits", name);
      end
      checks++;
      if (rd_exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got %h with no expected value queued", name, got);
      end else begin
         exp = rd_exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, got, exp);
         end
      end
      checks++;
      if (obs_oen[n+19] !== 1'b1) begin
         errors++;
         $display("FAIL %s release: oen=%b want 1 after D0", name, obs_oen[n+19]);
      end
      checks++;
      if (obs_busy[n+18] !== 1'b1 || obs_busy[n+19] !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_end: busy=%b,%b want 1,0", name, obs_busy[n+18], obs_busy[n+19]);
      end
   endtask

   task automatic check_silent(input string name, input int pre);
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < pre + 33; i++) if (obs_oen[i] !== 1'b1) quiet = 1'b0;
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL %s silent: mdio_oen asserted, want 1 for whole frame", name);
      end
   endtask

   task automatic expect_write(input string name, input logic [4:0] addr, input logic [15:0] data);
      logic [20:0] exp;
      exp = {addr, data};
      repeat (4) @(negedge clk);
      checks++;
      if (wr_seen_q.size() != 1) begin
         errors++;
         $display("FAIL %s wr_count: pulses=%0d want 1", name, wr_seen_q.size());
      end else if (wr_seen_q[0] !== exp) begin
         errors++;
         $display("FAIL %s wr_data: addr=%0d data=%h want addr=%0d data=%h",
                  name, wr_seen_q[0][20:16], wr_seen_q[0][15:0], addr, data);
      end
      wr_seen_q.delete();
   endtask

   task automatic do_read(input string name, input logic [4:0] regad, input logic [15:0] exp);
      rd_exp_q.push_back(exp);
      run_frame(1'b0, 5'd1, regad, 16'h0000, 2'b11, 32, -1);
      check_read(name, 32);
   endtask

   task automatic do_write(input string name, input logic [4:0] regad, input logic [15:0] data);
      run_frame(1'b1, 5'd1, regad, data, 2'b10, 32, -1);
      expect_write(name, regad, data);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (mdio_oen !== 1'b1 || mdio_out !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_drive: oen=%b out=%b busy=%b want 1 1 0", mdio_oen, mdio_out, busy);
      end
      checks++;
      if (reg_wr_pulse !== 1'b0 || reg_wr_addr !== 5'd0 || reg_wr_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_wr: pulse=%b addr=%0d data=%h want 0 0 0000",
                  reg_wr_pulse, reg_wr_addr, reg_wr_data);
      end
   endtask

   task automatic test_read_phyid2();
      do_read("rd_phyid2", 5'd3, 16'h0CC2);
   endtask

   task automatic test_write_readback();
      do_write("wr_reg4", 5'd4, 16'hA5C3);
      do_read("rd_reg4", 5'd4, 16'hA5C3);
   endtask

   task automatic test_foreign_phyad();
      run_frame(1'b0, 5'd2, 5'd3, 16'h0000, 2'b11, 32, -1);
      check_silent("foreign_phyad", 32);
      checks++;
      if (obs_busy[32+5] !== 1'b1 || obs_busy[32+9] !== 1'b0) begin
         errors++;
         $display("FAIL foreign_busy: busy mid/after PHYAD=%b,%b want 1,0",
                  obs_busy[32+5], obs_busy[32+9]);
      end
   endtask

   task automatic test_short_preamble();
      run_frame(1'b0, 5'd1, 5'd2, 16'h0000, 2'b11, 31, -1);
      check_silent("short_preamble", 31);
      do_read("full_preamble", 5'd2, 16'h0141);
   endtask

   task automatic test_bad_ta();
      run_frame(1'b1, 5'd1, 5'd5, 16'h5A5A, 2'b11, 32, -1);
      repeat (4) @(negedge clk);
      checks++;
      if (wr_seen_q.size() != 0) begin
         errors++;
         $display("FAIL bad_ta_commit: pulses=%0d want 0", wr_seen_q.size());
      end
      wr_seen_q.delete();
      do_read("bad_ta_reg5", 5'd5, 16'h0000);
   endtask

   task automatic test_soft_reset();
      do_write("wr_reg4_1234", 5'd4, 16'h1234);
      do_write("wr_bmcr_reset", 5'd0, 16'h8000);
      do_read("rd_bmcr", 5'd0, 16'h1140);
      do_read("rd_reg4_cleared", 5'd4, 16'h0000);
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] val;
      val = 16'hBEEF;
      do_write("wr_reg4_beef", 5'd4, val);
      // Stop after edge N+9, while D8 is on the wire.
      run_frame(1'b0, 5'd1, 5'd4, 16'h0000, 2'b11, 32, 32 + 13 + 10);
      repeat (2) @(negedge clk);
      checks++;
      if (mdio_oen !== 1'b0 || mdio_out !== val[8] || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_read_d8: oen=%b out=%b busy=%b want 0 %b 1",
                  mdio_oen, mdio_out, busy, val[8]);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (mdio_oen !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_read_reset: oen=%b busy=%b want 1 0", mdio_oen, busy);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      link_up = 1'b1;
      do_read("rd_bmsr_link", 5'd1, 16'h794D);
      do_read("rd_reg4_after_reset", 5'd4, 16'h0000);
   endtask

   initial begin
      reset   = 1'b1;
      mdc     = 1'b0;
      mdio_in = 1'b1;
      link_up = 1'b0;
      test_reset();
      test_read_phyid2();
      test_write_readback();
      test_foreign_phyad();
      test_short_preamble();
      test_bad_ta();
      test_soft_reset();
      test_reset_mid_read();
      checks++;
      if (rd_exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected reads left, want 0", rd_exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
